// File: rtl/divider_unit_if.sv
// Bus bundle between the pipeline and the iterative divider: the start
// request with its operands, the MTLO/MTHI write port, and the HI/LO
// result with its busy/ready status.
interface divider_unit_if #(
   parameter int WIDTH                = 32,
   parameter int LOHI_WRITE_OPT_WIDTH = 2
);

   logic                            start;
   logic                            is_signed;
   logic [WIDTH-1:0]                opr1;
   logic [WIDTH-1:0]                opr2;
   logic [LOHI_WRITE_OPT_WIDTH-1:0] write_opt;
   logic [WIDTH-1:0]                write_data;
   logic [2*WIDTH-1:0]              result;
   logic                            busy;
   logic                            ready;

   // Pipeline side: issues requests and register writes, reads HI/LO.
   modport master (
      output start, is_signed, opr1, opr2, write_opt, write_data,
      input  result, busy, ready
   );

   // Divider side: consumes requests, owns the HI/LO register.
   modport slave (
      input  start, is_signed, opr1, opr2, write_opt, write_data,
      output result, busy, ready
   );

endinterface

// File: rtl/divider_unit.sv
// Iterative restoring radix-2 divider with its own HI/LO register.
// DIV/DIVU leave the quotient in LO and the remainder in HI; MTLO/MTHI
// writes share the same register and may land in any state.
module divider_unit #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   divider_unit_if.slave bus
);

   localparam int CNT_WIDTH = $clog2(WIDTH);
   localparam int LOHI_WRITE_OPT_WIDTH = 2;
   localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_LO = 2'b01;
   localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_HI = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]       rem_q, rem_d;
   logic [WIDTH-1:0]       quo_q, quo_d;
   logic [WIDTH-1:0]       divisor_q, divisor_d;
   logic                   negQuo_q, negQuo_d;
   logic                   negRem_q, negRem_d;
   logic                   divZero_q, divZero_d;
   logic [2*WIDTH-1:0]     result_q, result_d;

   logic [WIDTH-1:0]       absOpr1;
   logic [WIDTH-1:0]       absOpr2;
   logic                   divisorZero;
   logic [WIDTH:0]         shifted;
   logic [WIDTH:0]         trialDiff;
   logic                   fits;
   logic [WIDTH-1:0]       quoFixed;
   logic [WIDTH-1:0]       remFixed;

   // Operand magnitudes, taken only for DIV so DIVU sees the raw bits, plus
   // the per-iteration trial subtraction and the final sign restoration.
   always_comb begin
      absOpr1     = (bus.is_signed && bus.opr1[WIDTH-1]) ? -bus.opr1 : bus.opr1;
      absOpr2     = (bus.is_signed && bus.opr2[WIDTH-1]) ? -bus.opr2 : bus.opr2;
      divisorZero = (bus.opr2 == '0);
      shifted     = {rem_q, quo_q[WIDTH-1]};
      trialDiff   = shifted - {1'b0, divisor_q};
      fits        = (shifted >= {1'b0, divisor_q});
      quoFixed    = negQuo_q ? -quo_q : quo_q;
      remFixed    = negRem_q ? -rem_q : rem_q;
   end

   // Next-state logic: sample on start, shift/subtract one bit per cycle,
   // then fix signs and commit; MTLO/MTHI override the addressed half last
   // so they win over the division result on the commit edge.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      negQuo_d  = negQuo_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      result_d  = result_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               rem_d     = '0;
               count_d   = '0;
               negQuo_d  = bus.is_signed & (bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1]);
               negRem_d  = bus.is_signed & bus.opr1[WIDTH-1];
               divZero_d = divisorZero;
               if (divisorZero) begin
                  quo_d     = bus.opr1;
                  divisor_d = '0;
                  state_d   = FIXUP;
               end else begin
                  quo_d     = absOpr1;
                  divisor_d = absOpr2;
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            count_d = count_q + 1'b1;
            if (fits) begin
               rem_d = trialDiff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (count_q == CNT_WIDTH'(WIDTH - 1)) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            state_d = IDLE;
            if (divZero_q) begin
               result_d = {quo_q, {WIDTH{1'b1}}};
            end else begin
               result_d = {remFixed, quoFixed};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (bus.write_opt == LOHI_WRITE_LO) begin
         result_d[WIDTH-1:0] = bus.write_data;
      end else if (bus.write_opt == LOHI_WRITE_HI) begin
         result_d[2*WIDTH-1:WIDTH] = bus.write_data;
      end
   end

   // State register; reset aborts any division without touching HI/LO
   // beyond clearing it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         negQuo_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         negQuo_q  <= negQuo_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         result_q  <= result_d;
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.ready  = (state_q == IDLE);

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed scenarios plus random
// divisions compared against plain integer division.
module tb_divider_unit;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_LO   = 2'b01;
   localparam logic [1:0] WR_HI   = 2'b10;
   localparam logic [1:0] WR_BAD  = 2'b11;

   logic clk = 1'b0;
   logic rst;
   int   testsRun    = 0;
   int   testsFailed = 0;
   logic [63:0] expResult;

   divider_unit_if #(.WIDTH(32), .LOHI_WRITE_OPT_WIDTH(2)) bus ();

   divider_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Reference: quotient truncates toward zero, remainder follows the
   // dividend sign; 64-bit arithmetic keeps 0x80000000 / -1 well defined.
   function automatic logic [63:0] refDivide(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive a one-cycle start; returns just after edge E0.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.opr1      = a;
      bus.opr2      = b;
      tick();
      bus.start     = 1'b0;
      bus.opr1      = $urandom;
      bus.opr2      = $urandom;
   endtask

   // Count edges after E0 until ready, bounded.
   task automatic runToDone(input int already, output int edges);
      edges = already;
      while (!bus.ready && edges < 100) begin
         tick();
         edges++;
      end
   endtask

   task automatic runDivision(input string tag, input logic sgn, input logic [31:0] a,
                              input logic [31:0] b);
      int n;
      applyStimulus(sgn, a, b);
      checkOutput({tag, " busy"}, 64'(bus.busy), 64'd1);
      runToDone(0, n);
      expResult = refDivide(sgn, a, b);
      checkOutput({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
      checkOutput({tag, " result"}, bus.result, expResult);
      checkOutput({tag, " ready"}, 64'(bus.ready), 64'd1);
   endtask

   initial begin
      int n;
      logic sgn;
      logic [31:0] a, b;

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.is_signed  = 1'b0;
      bus.opr1       = '0;
      bus.opr2       = '0;
      bus.write_opt  = WR_NONE;
      bus.write_data = '0;
      tick();
      tick();
      rst = 1'b0;
      expResult = 64'd0;
      checkOutput("reset result", bus.result, 64'd0);
      checkOutput("reset ready", 64'(bus.ready), 64'd1);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);

      // Directed divisions from the test plan.
      runDivision("divu 100/7", 1'b0, 32'd100, 32'd7);
      checkOutput("divu 100/7 const", bus.result, {32'd2, 32'd14});
      runDivision("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2);
      checkOutput("div -7/2 const", bus.result, {32'hFFFFFFFF, 32'hFFFFFFFD});
      runDivision("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE);
      checkOutput("div 7/-2 const", bus.result, {32'd1, 32'hFFFFFFFD});
      runDivision("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1);
      runDivision("divu 1234/0", 1'b0, 32'd1234, 32'd0);
      checkOutput("div0 const", bus.result, {32'd1234, 32'hFFFFFFFF});
      runDivision("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0);
      runDivision("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      checkOutput("div ovf const", bus.result, {32'd0, 32'h80000000});

      // Idle register writes and hold.
      bus.write_opt = WR_LO; bus.write_data = 32'h12345678;
      tick();
      expResult[31:0] = 32'h12345678;
      bus.write_opt = WR_BAD; bus.write_data = 32'hAAAAAAAA;
      tick();
      bus.write_opt = WR_NONE;
      repeat (5) tick();
      checkOutput("idle mtlo/hold", bus.result, expResult);

      // MTHI during CALC is visible next edge, then replaced at E33.
      applyStimulus(1'b0, 32'd1000, 32'd3);
      repeat (3) tick();
      bus.write_opt = WR_HI; bus.write_data = 32'h0000DEAD;
      tick();
      bus.write_opt = WR_NONE;
      checkOutput("mthi in calc", bus.result, {32'h0000DEAD, expResult[31:0]});
      runToDone(4, n);
      expResult = refDivide(1'b0, 32'd1000, 32'd3);
      checkOutput("mthi calc latency", 64'(n), 64'd33);
      checkOutput("mthi calc final", bus.result, expResult);

      // MTLO on the commit edge wins LO, HI keeps the remainder.
      applyStimulus(1'b1, -32'sd100, 32'd7);
      repeat (32) tick();
      checkOutput("pre-commit busy", 64'(bus.busy), 64'd1);
      bus.write_opt = WR_LO; bus.write_data = 32'h0000BEEF;
      tick();
      bus.write_opt = WR_NONE;
      expResult = refDivide(1'b1, -32'sd100, 32'd7);
      expResult[31:0] = 32'h0000BEEF;
      checkOutput("mtlo at commit", bus.result, expResult);
      checkOutput("mtlo commit ready", 64'(bus.ready), 64'd1);

      // Second start while busy is ignored.
      applyStimulus(1'b0, 32'd5000, 32'd9);
      repeat (4) tick();
      bus.start = 1'b1; bus.is_signed = 1'b1; bus.opr1 = 32'd77; bus.opr2 = 32'hFFFFFFFB;
      tick();
      bus.start = 1'b0;
      runToDone(5, n);
      expResult = refDivide(1'b0, 32'd5000, 32'd9);
      checkOutput("ignored start latency", 64'(n), 64'd33);
      checkOutput("ignored start result", bus.result, expResult);

      // Reset mid-division aborts; a fresh start completes at E44.
      applyStimulus(1'b0, 32'd12345, 32'd11);
      repeat (9) tick();
      rst = 1'b1; bus.write_opt = WR_HI; bus.write_data = 32'h55555555;
      tick();
      rst = 1'b0; bus.write_opt = WR_NONE;
      expResult = 64'd0;
      checkOutput("mid rst result", bus.result, expResult);
      checkOutput("mid rst ready", 64'(bus.ready), 64'd1);
      checkOutput("mid rst busy", 64'(bus.busy), 64'd0);
      runDivision("after rst", 1'b0, 32'd99, 32'd10);

      // Random divisions, some with tiny or zero divisors.
      for (int i = 0; i < 12; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case (i % 4)
            0:       b = $urandom_range(1, 20);
            1:       b = (i == 5) ? 32'd0 : $urandom;
            2:       b = -($urandom_range(1, 300));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if (b == 32'd0 && i != 5) b = 32'd3;
         runDivision($sformatf("rand%0d", i), sgn, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
